// File: rtl/aq_age_alloc.sv
// Age-matrix allocation queue: entries land in the lowest free slot and
// issue strictly in allocation order, tracked by an NUM x NUM age matrix
// (older[i][j] = 1 means entry j was allocated before entry i).
module aq_age_alloc #(
    parameter int NUM   = 4,
    parameter int WIDTH = 32,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_vld,
    input  logic [WIDTH-1:0] alloc_data,
    output logic             alloc_rdy,
    output logic [IDXW-1:0]  alloc_idx,
    output logic             issue_vld,
    output logic [WIDTH-1:0] issue_data,
    output logic [IDXW-1:0]  issue_idx,
    input  logic             issue_rdy,
    input  logic             flush,
    output logic [IDXW:0]    count
);

    logic [NUM-1:0]   valid;
    logic [NUM-1:0]   older [NUM];
    logic [WIDTH-1:0] payload [NUM];
    logic [IDXW:0]    count_q;

    logic [NUM-1:0]   oldest_oh;
    logic [NUM-1:0]   push_oh;
    logic [NUM-1:0]   pop_oh;
    logic             push;
    logic             pop;

    // Free-slot search: alloc_rdy and alloc_idx come from registered valid bits only
    always_comb begin
        alloc_rdy = ~&valid;
        alloc_idx = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (!valid[i]) alloc_idx = IDXW'(i);
        end
    end

    // Oldest-entry select: the one valid entry with no valid entry older than itself
    always_comb begin
        oldest_oh  = '0;
        issue_idx  = '0;
        issue_data = '0;
        for (int i = 0; i < NUM; i++) begin
            if (valid[i] && ((valid & older[i]) == '0)) begin
                oldest_oh[i] = 1'b1;
                issue_idx    = issue_idx | IDXW'(i);
                issue_data   = issue_data | payload[i];
            end
        end
        issue_vld = |valid;
    end

    // Handshake decode into one-hot push/pop vectors
    always_comb begin
        push = alloc_vld & alloc_rdy;
        pop  = issue_vld & issue_rdy;
        for (int i = 0; i < NUM; i++) begin
            push_oh[i] = push && (alloc_idx == IDXW'(i));
        end
        pop_oh = pop ? oldest_oh : '0;
    end

    // Control state: valid bits, age matrix and occupancy; rst/flush clear everything
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid   <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM; i++) older[i] <= '0;
        end else begin
            valid <= (valid & ~pop_oh) | push_oh;
            for (int i = 0; i < NUM; i++) begin
                // A new entry is younger than every survivor; popped and new columns are cleared
                if (push_oh[i]) older[i] <= valid & ~pop_oh;
                else            older[i] <= older[i] & ~pop_oh & ~push_oh;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage, not reset; a write during flush is harmless since valid is cleared
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM; i++) begin
            if (push_oh[i]) payload[i] <= alloc_data;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_aq_age_alloc.sv
// Self-checking bench for aq_age_alloc: directed scenarios plus a randomized
// run against a FIFO scoreboard model of slot occupancy and issue order.
module tb_aq_age_alloc;

    localparam int NUM   = 4;
    localparam int WIDTH = 32;
    localparam int IDXW  = 2;

    logic             clk;
    logic             rst;
    logic             alloc_vld;
    logic [WIDTH-1:0] alloc_data;
    logic             alloc_rdy;
    logic [IDXW-1:0]  alloc_idx;
    logic             issue_vld;
    logic [WIDTH-1:0] issue_data;
    logic [IDXW-1:0]  issue_idx;
    logic             issue_rdy;
    logic             flush;
    logic [IDXW:0]    count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [IDXW-1:0]  idx;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t           sb[$];
    logic [NUM-1:0] mvalid;

    aq_age_alloc #(.NUM(NUM), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_vld  (alloc_vld),
        .alloc_data (alloc_data),
        .alloc_rdy  (alloc_rdy),
        .alloc_idx  (alloc_idx),
        .issue_vld  (issue_vld),
        .issue_data (issue_data),
        .issue_idx  (issue_idx),
        .issue_rdy  (issue_rdy),
        .flush      (flush),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IDXW-1:0] m_free();
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (!mvalid[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    // Apply one cycle of stimulus, update the scoreboard model, advance past the edge
    task automatic drive(input logic av, input logic [WIDTH-1:0] ad, input logic ir,
                         input logic fl, input logic r);
        logic            m_push;
        logic            m_pop;
        logic [IDXW-1:0] nidx;
        ent_t            e;
        alloc_vld  = av;
        alloc_data = ad;
        issue_rdy  = ir;
        flush      = fl;
        rst        = r;
        m_push = av && (mvalid != {NUM{1'b1}});
        m_pop  = ir && (sb.size() > 0);
        nidx   = m_free();
        if (r || fl) begin
            sb.delete();
            mvalid = '0;
        end else begin
            if (m_pop) begin
                e = sb.pop_front();
                mvalid[e.idx] = 1'b0;
            end
            if (m_push) begin
                e.idx  = nidx;
                e.data = ad;
                sb.push_back(e);
                mvalid[nidx] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        alloc_vld = 1'b0;
        issue_rdy = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL reset_alloc_rdy: got %b expected 1", alloc_rdy); end
        checks++; if (alloc_idx !== 2'd0) begin errors++; $display("FAIL reset_alloc_idx: got %0d expected 0", alloc_idx); end
        checks++; if (issue_vld !== 1'b0) begin errors++; $display("FAIL reset_issue_vld: got %b expected 0", issue_vld); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    endtask

    task automatic test_fifo_order();
        logic [WIDTH-1:0] d [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (alloc_idx !== IDXW'(i)) begin errors++; $display("FAIL order_alloc_idx%0d: got %0d expected %0d", i, alloc_idx, i); end
            drive(1'b1, d[i], 1'b0, 1'b0, 1'b0);
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL order_count: got %0d expected 3", count); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (issue_vld !== 1'b1) begin errors++; $display("FAIL order_issue_vld%0d: got %b expected 1", i, issue_vld); end
            checks++; if (issue_idx !== IDXW'(i)) begin errors++; $display("FAIL order_issue_idx%0d: got %0d expected %0d", i, issue_idx, i); end
            checks++; if (issue_data !== d[i]) begin errors++; $display("FAIL order_issue_data%0d: got %h expected %h", i, issue_data, d[i]); end
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (issue_vld !== 1'b0) begin errors++; $display("FAIL order_empty: got %b expected 0", issue_vld); end
    endtask

    task automatic test_full();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NUM; i++) drive(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0, 1'b0);
        checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL full_alloc_rdy: got %b expected 0", alloc_rdy); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
        drive(1'b1, 32'hBAD0_0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_held_count: got %0d expected 4", count); end
        checks++; if (issue_idx !== 2'd0) begin errors++; $display("FAIL full_issue_idx: got %0d expected 0", issue_idx); end
        checks++; if (issue_data !== 32'hD000_0000) begin errors++; $display("FAIL full_issue_data: got %h expected d0000000", issue_data); end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL full_pop_rdy: got %b expected 1", alloc_rdy); end
        checks++; if (alloc_idx !== 2'd0) begin errors++; $display("FAIL full_pop_idx: got %0d expected 0", alloc_idx); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d expected 3", count); end
    endtask

    task automatic test_wrap();
        logic [IDXW-1:0]  ei [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        logic [WIDTH-1:0] ed [4] = '{32'hE000_0002, 32'hE000_0003, 32'h0000_00AA, 32'h0000_00BB};
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NUM; i++) drive(1'b1, 32'hE000_0000 + i, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (issue_idx !== IDXW'(i)) begin errors++; $display("FAIL wrap_pop_idx%0d: got %0d expected %0d", i, issue_idx, i); end
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (alloc_idx !== 2'd0) begin errors++; $display("FAIL wrap_x_idx: got %0d expected 0", alloc_idx); end
        drive(1'b1, 32'h0000_00AA, 1'b0, 1'b0, 1'b0);
        checks++; if (alloc_idx !== 2'd1) begin errors++; $display("FAIL wrap_y_idx: got %0d expected 1", alloc_idx); end
        drive(1'b1, 32'h0000_00BB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (issue_idx !== ei[i]) begin errors++; $display("FAIL wrap_issue_idx%0d: got %0d expected %0d", i, issue_idx, ei[i]); end
            checks++; if (issue_data !== ed[i]) begin errors++; $display("FAIL wrap_issue_data%0d: got %h expected %h", i, issue_data, ed[i]); end
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (issue_vld !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b expected 0", issue_vld); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h5000_0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h5000_0001, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count_pre: got %0d expected 2", count); end
        drive(1'b1, 32'h5000_0002, 1'b1, 1'b0, 1'b0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", count); end
        checks++; if (issue_idx !== 2'd1) begin errors++; $display("FAIL b2b_idx_first: got %0d expected 1", issue_idx); end
        checks++; if (issue_data !== 32'h5000_0001) begin errors++; $display("FAIL b2b_data_first: got %h expected 50000001", issue_data); end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (issue_idx !== 2'd2) begin errors++; $display("FAIL b2b_idx_last: got %0d expected 2", issue_idx); end
        checks++; if (issue_data !== 32'h5000_0002) begin errors++; $display("FAIL b2b_data_last: got %h expected 50000002", issue_data); end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (issue_vld !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", issue_vld); end
    endtask

    task automatic test_flush();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hF000_0000 + i, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_count_pre: got %0d expected 3", count); end
        alloc_vld = 1'b1;
        flush     = 1'b1;
        #1;
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL flush_rdy_during: got %b expected 1", alloc_rdy); end
        drive(1'b1, 32'hF000_00FF, 1'b1, 1'b1, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (issue_vld !== 1'b0) begin errors++; $display("FAIL flush_issue_vld: got %b expected 0", issue_vld); end
        checks++; if (alloc_idx !== 2'd0) begin errors++; $display("FAIL flush_alloc_idx: got %0d expected 0", alloc_idx); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (issue_vld !== 1'b0) begin errors++; $display("FAIL flush_stays_empty: got %b expected 0", issue_vld); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h7000_0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h7000_0001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h7000_0002, 1'b1, 1'b0, 1'b1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
        checks++; if (issue_vld !== 1'b0) begin errors++; $display("FAIL rstmid_issue_vld: got %b expected 0", issue_vld); end
        checks++; if (alloc_idx !== 2'd0) begin errors++; $display("FAIL rstmid_alloc_idx: got %0d expected 0", alloc_idx); end
    endtask

    task automatic test_random();
        logic             av;
        logic             ir;
        logic             fl;
        logic [WIDTH-1:0] ad;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 10000; n++) begin
            checks++; if (alloc_rdy !== (mvalid != {NUM{1'b1}})) begin errors++; $display("FAIL rnd_alloc_rdy @%0d: got %b expected %b", n, alloc_rdy, (mvalid != {NUM{1'b1}})); end
            if (mvalid != {NUM{1'b1}}) begin
                checks++; if (alloc_idx !== m_free()) begin errors++; $display("FAIL rnd_alloc_idx @%0d: got %0d expected %0d", n, alloc_idx, m_free()); end
            end
            checks++; if (issue_vld !== (sb.size() > 0)) begin errors++; $display("FAIL rnd_issue_vld @%0d: got %b expected %b", n, issue_vld, (sb.size() > 0)); end
            if (sb.size() > 0) begin
                checks++; if (issue_idx !== sb[0].idx) begin errors++; $display("FAIL rnd_issue_idx @%0d: got %0d expected %0d", n, issue_idx, sb[0].idx); end
                checks++; if (issue_data !== sb[0].data) begin errors++; $display("FAIL rnd_issue_data @%0d: got %h expected %h", n, issue_data, sb[0].data); end
            end
            checks++; if (count !== ($countones(mvalid))) begin errors++; $display("FAIL rnd_count @%0d: got %0d expected %0d", n, count, $countones(mvalid)); end
            av = ($urandom_range(0, 9) < 6);
            ir = ($urandom_range(0, 9) < 5);
            fl = ($urandom_range(0, 99) == 0);
            ad = $urandom;
            drive(av, ad, ir, fl, 1'b0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        alloc_vld  = 1'b0;
        alloc_data = '0;
        issue_rdy  = 1'b0;
        flush      = 1'b0;
        mvalid     = '0;
        test_reset();
        test_fifo_order();
        test_full();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aq_age_alloc.md
AQ_AGE_ALLOC -- requirements
Module: aq_age_alloc

Interface
REQ-001 Parameter NUM, default 4: number of buffer entries, legal range 2..16.
REQ-002 Parameter WIDTH, default 32: payload width in bits.
REQ-003 Parameter IDXW, default 2: entry index width; SHALL equal ceil(log2(NUM)).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 alloc_vld  in  1  producer offers one entry.
REQ-007 alloc_data  in  WIDTH  payload to store.
REQ-008 alloc_rdy  out  1  a free entry exists.
REQ-009 alloc_idx  out  IDXW  entry index the offered payload will occupy.
REQ-010 issue_vld  out  1  at least one entry is occupied.
REQ-011 issue_data  out  WIDTH  payload of the oldest occupied entry.
REQ-012 issue_idx  out  IDXW  index of the oldest occupied entry.
REQ-013 issue_rdy  in  1  consumer accepts the issued entry.
REQ-014 flush  in  1  discard all entries.
REQ-015 count  out  IDXW+1  number of occupied entries.

Function
REQ-016 State: per-entry valid bit, WIDTH payload, and an NUM x NUM age matrix where older[i][j]=1 means entry j is older than entry i.
REQ-017 Allocation handshake: alloc fires when alloc_vld and alloc_rdy are both 1 in a cycle; alloc_rdy SHALL NOT depend on alloc_vld.
REQ-018 alloc_rdy = 1 iff any valid bit is 0, evaluated on registered state only; an entry freed in the same cycle is not reusable until the next cycle.
REQ-019 alloc_idx = lowest-numbered free entry; its value when alloc_rdy=0 is don't-care.
REQ-020 On alloc into entry k, the next cycle SHALL have: valid[k]=1; payload[k]=alloc_data; row k of older = valid & ~pop_onehot; older[j][k]=0 for all j.
REQ-021 Issue handshake: pop fires when issue_vld and issue_rdy are both 1; issue outputs SHALL be combinational from registered state only, with no path from alloc_* or issue_rdy.
REQ-022 Selection: entry i is oldest iff valid[i]=1 and (valid & older[i]) = 0; exactly one entry qualifies whenever issue_vld=1.
REQ-023 On pop of entry j, the next cycle SHALL have: valid[j]=0 and column j of older cleared in every row.
REQ-024 An alloc and a pop in the same cycle SHALL both complete, and count SHALL stay unchanged.
REQ-025 count increments by 1 on alloc-only and decrements by 1 on pop-only; it SHALL never exceed NUM or wrap below 0.
REQ-026 Entries issue in strict allocation order (FIFO) regardless of index, including after index wrap-around or non-contiguous free slots.
REQ-027 flush=1: next cycle all valid bits, the whole age matrix and count are 0; a same-cycle alloc or pop is discarded; alloc_rdy is unaffected during the flush cycle.
REQ-028 When empty, issue_vld=0 and issue_data and issue_idx are don't-care; when full, alloc_rdy=0 and alloc_vld is ignored.

Reset
REQ-029 rst=1 at a rising edge: next cycle all valid bits=0, age matrix=0, count=0; payload registers need not be reset.
REQ-030 Output values after reset: alloc_rdy=1, alloc_idx=0, issue_vld=0.
REQ-031 rst has priority over flush, alloc and pop; rst asserted mid-operation discards all entries in the same way.

Verification
REQ-032 Sequence: reset; alloc A,B,C on consecutive cycles, issue_rdy=0 -> idx 0,1,2 used, count=3; then issue_rdy=1 -> A,B,C issued in order, issue_vld=0 after the third pop.
REQ-033 NUM=4, fill 4 entries -> alloc_rdy=0, count=4; a held alloc_vld is not accepted; pop idx0 -> alloc_rdy=1 the next cycle, alloc_idx=0.
REQ-034 Sequence with 4 entries: pop idx0 and idx1; alloc X (lands in idx0) then Y (lands in idx1) -> issue order is idx2, idx3, X, Y.
REQ-035 count=2; alloc and pop in the same cycle -> count stays 2; the new entry issues last.
REQ-036 With 3 entries held, flush coincident with alloc_vld=1 and a pop -> next cycle count=0, issue_vld=0, nothing stored.
REQ-037 Random alloc/pop/flush for 10k cycles against a FIFO scoreboard -> order and payload always match; count equals the number of set valid bits.
